// File: rtl/cmp_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
// Shared types and constants for consumers of the magnitude comparator's
// result flags (a_greater / equal / b_greater).
//
// Contents:
//   VERDICT_TIE/VERDICT_A/VERDICT_B  2-bit majority verdict encodings
//   cmp_tally_state_t                window tally FSM states
//   cmp_class_t                      one-hot decoded comparison class
//   cmp_verdict()                    majority rule on the A and B counts
// -----------------------------------------------------------------------------
package cmp_pkg;

    localparam logic [1:0] VERDICT_TIE = 2'b00;
    localparam logic [1:0] VERDICT_A   = 2'b01;
    localparam logic [1:0] VERDICT_B   = 2'b10;

    typedef enum logic {
        COLLECT = 1'b0,
        REPORT  = 1'b1
    } cmp_tally_state_t;

    // Exactly one field is set for any flag combination.
    typedef struct packed {
        logic a;
        logic eq;
        logic b;
    } cmp_class_t;

    // The equal count deliberately plays no part in the verdict.
    function automatic logic [1:0] cmp_verdict(input int unsigned n_a,
                                               input int unsigned n_b);
        if (n_a > n_b)      return VERDICT_A;
        else if (n_b > n_a) return VERDICT_B;
        else                return VERDICT_TIE;
    endfunction

endpackage

// File: rtl/cmp_flag_decode.sv
// -----------------------------------------------------------------------------
// cmp_flag_decode
// Purely combinational decode of the comparator's three result flags into a
// one-hot class, using the priority a_greater > b_greater > equal. All-zero
// or multi-hot flag sets therefore still map to a single class.
//
// Ports:
//   a_greater, equal, b_greater  in   raw comparator flags
//   cls                          out  one-hot class (cmp_class_t)
//   onehot_ok                    out  1 when exactly one raw flag is set
// -----------------------------------------------------------------------------
module cmp_flag_decode
    import cmp_pkg::*;
(
    input  logic       a_greater,
    input  logic       equal,
    input  logic       b_greater,
    output cmp_class_t cls,
    output logic       onehot_ok
);

    assign cls.a  = a_greater;
    assign cls.b  = ~a_greater & b_greater;
    assign cls.eq = ~a_greater & ~b_greater;

    // XOR is 1 for one or three set flags; the AND term removes the three case.
    assign onehot_ok = (a_greater ^ equal ^ b_greater)
                     & ~(a_greater & equal & b_greater);

endmodule

// File: rtl/cmp_window_tally.sv
// -----------------------------------------------------------------------------
// cmp_window_tally
// Collects WINDOW accepted comparator results, then offers the per-outcome
// counts and an A-vs-B majority verdict on a valid/ready report interface.
// While a report is pending no samples are accepted. Report outputs hold the
// last report's values until the next window closes.
//
// Build option:
//   CMP_ONEHOT_CHECK_EN  when defined, accepted samples whose flags are not
//                        exactly one-hot are dropped and set a sticky err_flag;
//                        when undefined, err_flag is tied 0 and every sample
//                        is classified by priority.
//
// Parameters:
//   WINDOW  accepted samples per report (>= 1)
//   CNT_W   count width, 2**CNT_W > WINDOW
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   in_valid / in_ready            sample handshake
//   a_greater, equal, b_greater    comparator flags
//   out_valid / out_ready          report handshake
//   cnt_a, cnt_eq, cnt_b           counts of the last report
//   verdict                        00 tie, 01 A majority, 10 B majority
//   err_flag                       sticky malformed-sample indicator
// -----------------------------------------------------------------------------
module cmp_window_tally
    import cmp_pkg::*;
#(
    parameter int WINDOW = 8,
    parameter int CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a_greater,
    input  logic             equal,
    input  logic             b_greater,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_eq,
    output logic [CNT_W-1:0] cnt_b,
    output logic [1:0]       verdict,
    output logic             err_flag
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

    cmp_tally_state_t state;
    cmp_tally_state_t state_next;

    cmp_class_t       cls;
    logic             onehot_ok;
    logic             sample_ok;
    logic             accept;
    logic             take;
    logic             close;
    logic             handshake;

    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] acc_a;
    logic [CNT_W-1:0] acc_eq;
    logic [CNT_W-1:0] acc_b;
    logic [CNT_W-1:0] sum_a;
    logic [CNT_W-1:0] sum_eq;
    logic [CNT_W-1:0] sum_b;

    cmp_flag_decode u_decode (
        .a_greater (a_greater),
        .equal     (equal),
        .b_greater (b_greater),
        .cls       (cls),
        .onehot_ok (onehot_ok)
    );

`ifdef CMP_ONEHOT_CHECK_EN
    assign sample_ok = onehot_ok;
`else
    logic unused_onehot_ok;
    assign unused_onehot_ok = onehot_ok;
    assign sample_ok        = 1'b1;
`endif

    assign accept    = in_valid & in_ready;
    assign take      = accept & sample_ok;
    assign close     = take & (idx == LAST_IDX);
    assign handshake = out_valid & out_ready;

    // Running totals including the sample currently being taken.
    assign sum_a  = acc_a  + CNT_W'(cls.a);
    assign sum_eq = acc_eq + CNT_W'(cls.eq);
    assign sum_b  = acc_b  + CNT_W'(cls.b);

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values of its inputs regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= COLLECT;
        else     state <= state_next;
    end

    // NOTE: default assignment first so no path through the case leaves
    // state_next unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (close)     state_next = REPORT;
            REPORT:  if (out_ready) state_next = COLLECT;
            default:                state_next = COLLECT;
        endcase
    end

    // Handshake outputs come straight from the registered state, so an async
    // reset drops out_valid immediately.
    always_comb begin
        in_ready  = (state == COLLECT);
        out_valid = (state == REPORT);
    end

    // ------------------------------------------------------- accumulation
    // NOTE: these few counters are cleared by reset because they gate the
    // next report; a large sample store would not be reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            acc_a  <= '0;
            acc_eq <= '0;
            acc_b  <= '0;
        end else if (handshake) begin
            idx    <= '0;
            acc_a  <= '0;
            acc_eq <= '0;
            acc_b  <= '0;
        end else if (take) begin
            // The closing sample leaves idx at WINDOW, which still fits CNT_W.
            idx    <= idx + CNT_W'(1);
            acc_a  <= sum_a;
            acc_eq <= sum_eq;
            acc_b  <= sum_b;
        end
    end

    // ------------------------------------------------------ report outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_a   <= '0;
            cnt_eq  <= '0;
            cnt_b   <= '0;
            verdict <= VERDICT_TIE;
        end else if (close) begin
            cnt_a   <= sum_a;
            cnt_eq  <= sum_eq;
            cnt_b   <= sum_b;
            verdict <= cmp_verdict(32'(sum_a), 32'(sum_b));
        end
    end

    // ---------------------------------------------------------- err_flag
`ifdef CMP_ONEHOT_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      err_flag <= 1'b0;
        else if (accept & ~onehot_ok) err_flag <= 1'b1;
    end
`else
    assign err_flag = 1'b0;
`endif

endmodule

// File: doc/cmp_window_tally.md
Name: cmp_window_tally

Overview:
- Downstream consumer of the magnitude comparator's three result flags (a_greater, equal, b_greater).
- Accumulates WINDOW accepted comparison results, then presents per-outcome counts and a majority verdict on a valid/ready output.
- Sits between the comparator and any controller that acts on aggregate comparison statistics rather than single results.

Parameters:
- WINDOW, 8, number of accepted samples per report; legal range is 1 or greater.
- CNT_W, 4, width of the count outputs; must satisfy 2**CNT_W > WINDOW.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  comparator flags valid this cycle.
- in_ready  output  1  block can accept a sample.
- a_greater  input  1  comparator flag: a > b.
- equal  input  1  comparator flag: a == b.
- b_greater  input  1  comparator flag: a < b.
- out_valid  output  1  report available.
- out_ready  input  1  consumer accepts report.
- cnt_a  output  CNT_W  a_greater count of the last report.
- cnt_eq  output  CNT_W  equal count of the last report.
- cnt_b  output  CNT_W  b_greater count of the last report.
- verdict  output  2  2'b00 = tie, 2'b01 = A majority, 2'b10 = B majority.
- err_flag  output  1  sticky malformed-sample indicator; tied 0 without the optional feature.

Behaviour:
- Reset (async, immediate):
  - state = COLLECT; internal counters and sample index = 0.
  - out_valid = 0, in_ready = 1.
  - cnt_a/cnt_eq/cnt_b = 0, verdict = 00, err_flag = 0.
- FSM has two states, COLLECT and REPORT. in_ready = (state == COLLECT), decoded from registered state.
- COLLECT:
  - A sample is accepted on a rising edge when in_valid && in_ready.
  - Classification priority: a_greater, then b_greater, else equal. All-zero flags count as equal.
  - Each accepted sample increments the matching internal counter and the index.
  - Counters never exceed WINDOW, so no wrap is possible.
- Window close, on acceptance of the sample with index == WINDOW-1:
  - Next cycle: state = REPORT, out_valid = 1.
  - cnt_* output registers load the final counts, including the closing sample.
  - verdict loads: 01 if cnt_a > cnt_b, 10 if cnt_b > cnt_a, else 00. The equal count never affects verdict.
  - Latency: out_valid rises exactly 1 cycle after the closing sample is accepted.
- REPORT:
  - in_ready = 0; offered samples are ignored.
  - out_valid and all report outputs are held stable until out_valid && out_ready.
  - On handshake: next cycle out_valid = 0, in_ready = 1, state = COLLECT, internal counters and index cleared.
  - No same-cycle bypass: a sample offered in the handshake cycle is not accepted.
- cnt_*/verdict keep the previous report's values during COLLECT; they change only at window close.
- WINDOW = 1: every accepted sample produces a report, giving a maximum of one accepted sample per 2 cycles under continuous out_ready.
- Reset asserted mid-COLLECT or mid-REPORT discards partial counts and any pending report immediately.

Optional Feature:
- Macro: CMP_ONEHOT_CHECK_EN.
- Defined:
  - An accepted sample whose flags are not exactly one-hot is discarded: no counter increment, index not advanced.
  - err_flag sets the following cycle and holds until rst.
- Undefined:
  - err_flag is tied 0.
  - Malformed samples are classified by the priority rule above.

Decomposition:
- Package cmp_pkg holds:
  - verdict encodings VERDICT_TIE = 2'b00, VERDICT_A = 2'b01, VERDICT_B = 2'b10;
  - the state typedef cmp_tally_state_t {COLLECT, REPORT}.
- One sub-module, cmp_flag_decode: combinational. Maps the three flags to a one-hot class plus an onehot_ok bit. Reused by any later consumer of comparator flags.

Test Plan:
- Reset behaviour: hold rst = 1 across a clock edge, then release → out_valid 0, in_ready 1, counts 0, verdict 00. Reassert rst while in REPORT → out_valid drops immediately, before the next edge.
- Basic window (WINDOW = 4, out_ready = 1): continuous samples A, A, B, EQ → one cycle after the 4th accept, out_valid = 1 for 1 cycle; cnt_a = 2, cnt_b = 1, cnt_eq = 1, verdict 01; in_ready returns to 1 the cycle after the handshake.
- Backpressure: samples B, B, B, A with out_ready = 0 for 5 cycles while in_valid stays 1 → out_valid held, cnt_b = 3, cnt_a = 1, verdict 10, all outputs stable, in_ready 0, nothing counted; raise out_ready → handshake; the next window starts from zero counts.
- Tie and gaps: in_valid toggling 1,0,1,0,... carrying A, B, EQ, EQ on the valid cycles → only valid cycles are counted; verdict 00, cnt_eq = 2.
- Malformed flags: sample {a_greater = 1, equal = 1, b_greater = 0} inside an otherwise clean window.
  - With CMP_ONEHOT_CHECK_EN: err_flag 1, sample skipped, report arrives only after 4 good samples.
  - Without: the sample is counted as A, and err_flag stays 0.
- WINDOW = 1 with a continuous A stream and out_ready = 1 → out_valid pulses every other cycle, each report cnt_a = 1, verdict 01.
